// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient stage.
// Buffers two image lines and a 3x3 window, and emits saturated |Gx| and |Gy|
// for every interior pixel through a one-entry valid/ready output register.
module sobel_gradient #(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 640,
    parameter int IMG_H_P = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] pix_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] gx_o,
    output logic [WIDTH_P-1:0] gy_o,
    output logic               last_o
);

    localparam int CW = (IMG_W_P > 2) ? $clog2(IMG_W_P) : 2;
    localparam int RW = (IMG_H_P > 2) ? $clog2(IMG_H_P) : 2;
    localparam int SW = WIDTH_P + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_P - 1);
    localparam logic [SW-1:0] MAX_V    = SW'((2 ** WIDTH_P) - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb0 holds the previous line, lb1 the line before it, both indexed by column
    logic [WIDTH_P-1:0] lb0 [IMG_W_P];
    logic [WIDTH_P-1:0] lb1 [IMG_W_P];

    // win[y][x]: y=0 top row, x=0 left column
    logic [WIDTH_P-1:0] win [3][3];
    logic [WIDTH_P-1:0] nw  [3][3];

    logic acc;
    logic producing;
    logic col_wrap;
    logic row_wrap;
    logic last_beat;

    logic [SW-1:0]        gx_pos;
    logic [SW-1:0]        gx_neg;
    logic [SW-1:0]        gy_pos;
    logic [SW-1:0]        gy_neg;
    logic signed [SW-1:0] gx_s;
    logic signed [SW-1:0] gy_s;
    logic [WIDTH_P-1:0]   gx_c;
    logic [WIDTH_P-1:0]   gy_c;

    function automatic logic [SW-1:0] ext(input logic [WIDTH_P-1:0] p);
        return {3'b000, p};
    endfunction

    function automatic logic [WIDTH_P-1:0] clip_abs(input logic signed [SW-1:0] v);
        logic [SW-1:0] mag;
        mag = v[SW-1] ? $unsigned(-v) : $unsigned(v);
        if (mag > MAX_V) begin
            return '1;
        end
        return mag[WIDTH_P-1:0];
    endfunction

    assign ready_o   = ~valid_o | ready_i;
    assign acc       = valid_i & ready_o;
    assign col_wrap  = (col == COL_LAST);
    assign row_wrap  = (row == ROW_LAST);
    assign last_beat = col_wrap & row_wrap;
    assign producing = (row >= RW'(2)) && (col >= CW'(2));

    // Window as it will look after this beat: shift left, new column from line buffers and pixel
    always_comb begin
        for (int y = 0; y < 3; y++) begin
            nw[y][0] = win[y][1];
            nw[y][1] = win[y][2];
        end
        nw[0][2] = lb1[col];
        nw[1][2] = lb0[col];
        nw[2][2] = pix_i;
    end

    // Sobel kernels on the post-shift window, widened so the difference cannot overflow
    always_comb begin
        gx_pos = ext(nw[0][2]) + (ext(nw[1][2]) << 1) + ext(nw[2][2]);
        gx_neg = ext(nw[0][0]) + (ext(nw[1][0]) << 1) + ext(nw[2][0]);
        gy_pos = ext(nw[2][0]) + (ext(nw[2][1]) << 1) + ext(nw[2][2]);
        gy_neg = ext(nw[0][0]) + (ext(nw[0][1]) << 1) + ext(nw[0][2]);
        gx_s   = signed'(gx_pos - gx_neg);
        gy_s   = signed'(gy_pos - gy_neg);
        gx_c   = clip_abs(gx_s);
        gy_c   = clip_abs(gy_s);
    end

    // Raster position of the next pixel to be accepted; reset realigns to frame start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers and window carry pixel data only, so they are left unreset
    always_ff @(posedge clk_i) begin
        if (acc) begin
            lb0[col] <= pix_i;
            lb1[col] <= lb0[col];
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < 3; x++) begin
                    win[y][x] <= nw[y][x];
                end
            end
        end
    end

    // One-entry output stage: load on interior beats, drain on handshake, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            gx_o    <= '0;
            gy_o    <= '0;
        end else if (acc && producing) begin
            valid_o <= 1'b1;
            last_o  <= last_beat;
            gx_o    <= gx_c;
            gy_o    <= gy_c;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
